// File: rtl/ifu_fetch_if.sv
// Fetch-unit handshake bundle: imem request/response, decode delivery and redirect.
// master = fetch unit, slave = memory/decode environment.
interface ifu_fetch_if;
   logic        redirect;
   logic [31:0] redirectPC;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemReady;
   logic        imemRvalid;
   logic [31:0] imemRdata;
   logic        instrValid;
   logic        idReady;
   logic [31:0] instrOut;
   logic [31:0] pcOut;
   logic        excAdEL;

   modport master (
      input  redirect, redirectPC, imemReady, imemRvalid, imemRdata, idReady,
      output imemReq, imemAddr, instrValid, instrOut, pcOut, excAdEL
   );

   modport slave (
      output redirect, redirectPC, imemReady, imemRvalid, imemRdata, idReady,
      input  imemReq, imemAddr, instrValid, instrOut, pcOut, excAdEL
   );
endinterface

// File: rtl/ifu_fetch.sv
// Single-outstanding instruction fetch front end with one-delay-slot redirect handling.
// Delivers each fetched word with its PC to decode over a valid/ready handshake.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset_n,
   ifu_fetch_if.master fif
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t            state;
   logic [XLEN-1:0]   fetch_pc;
   logic [XLEN-1:0]   cur_pc;
   logic [XLEN-1:0]   pend_tgt;
   logic              pend_valid;
   logic [XLEN-1:0]   instr_q;
   logic [XLEN-1:0]   pc_q;
   logic              exc_q;
   logic              aligned;

   // Request and valid decode only from registered state, never from memory inputs
   assign aligned        = (fetch_pc[1:0] == 2'b00);
   assign fif.imemReq    = (state == IDLE) && aligned;
   assign fif.imemAddr   = fetch_pc;
   assign fif.instrValid = (state == HOLD);
   assign fif.instrOut   = instr_q;
   assign fif.pcOut      = pc_q;
   assign fif.excAdEL    = exc_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         cur_pc     <= '0;
         pend_tgt   <= '0;
         pend_valid <= 1'b0;
         instr_q    <= '0;
         pc_q       <= '0;
         exc_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (aligned) begin
                  if (fif.imemReady) begin
                     state      <= WAIT;
                     cur_pc     <= fetch_pc;
                     pend_valid <= 1'b0;
                     // Accepted request is the delay slot when a target is already known
                     if (fif.redirect)
                        fetch_pc <= fif.redirectPC;
                     else if (pend_valid)
                        fetch_pc <= pend_tgt;
                     else
                        fetch_pc <= fetch_pc + XLEN'(4);
                  end else if (fif.redirect) begin
                     pend_valid <= 1'b1;
                     pend_tgt   <= fif.redirectPC;
                  end
               end else begin
                  state   <= HOLD;
                  instr_q <= '0;
                  pc_q    <= fetch_pc;
                  exc_q   <= 1'b1;
                  // A misaligned PC is never issued, so a redirect simply replaces it
                  if (fif.redirect) begin
                     fetch_pc   <= fif.redirectPC;
                     pend_valid <= 1'b0;
                  end
               end
            end
            WAIT: begin
               if (fif.imemRvalid) begin
                  state   <= HOLD;
                  instr_q <= fif.imemRdata;
                  pc_q    <= cur_pc;
                  exc_q   <= 1'b0;
               end
               if (fif.redirect) begin
                  fetch_pc   <= fif.redirectPC;
                  pend_valid <= 1'b0;
               end
            end
            HOLD: begin
               if (fif.idReady)
                  state <= IDLE;
               if (fif.redirect) begin
                  fetch_pc   <= fif.redirectPC;
                  pend_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Sequential instruction-fetch front end for the five-stage MIPS core. It owns the fetch PC register and issues one instruction-memory request at a time over a request/response handshake. It applies the redirect target produced by the next-PC logic with one architectural delay slot, and presents each fetched instruction with its PC to the decode stage under a valid/ready handshake.

## Interface
- `RESET_PC`, default 32'h0000_3000: fetch PC after reset.
- `clk`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `redirect`  in  1  one-cycle pulse from decode: a jump or taken branch is resolved.
- `redirectPC`  in  32  target from the next-PC calculator, valid with `redirect`.
- `imemReq`  out  1  fetch request valid.
- `imemAddr`  out  32  fetch byte address, always word aligned when `imemReq`=1.
- `imemReady`  in  1  memory accepts the request this cycle.
- `imemRvalid`  in  1  read data valid, with latency of 1 or more cycles after acceptance.
- `imemRdata`  in  32  instruction word.
- `instrValid`  out  1  `instrOut`/`pcOut` hold a fetched instruction.
- `idReady`  in  1  decode consumes the instruction (low while the hazard unit stalls).
- `instrOut`  out  32  instruction word (32'h0 when an exception is flagged).
- `pcOut`  out  32  PC of `instrOut`.
- `excAdEL`  out  1  fetch-address exception, qualified by `instrValid`.

## Operation
- State register: IDLE, WAIT, HOLD. At most one instruction is in flight or buffered at any time.
- IDLE:
  - If `fetchPC[1:0]`==0: drive `imemReq`=1 and `imemAddr`=`fetchPC`. On `imemReady`, go to WAIT and set `curPC`<=`fetchPC`.
  - On acceptance, `fetchPC` <= `redirectPC` if `redirect` is high this cycle; else `pendTgt` if `pendValid` is set (clear `pendValid`); else `fetchPC`+4.
  - If `fetchPC[1:0]`!=0: issue no request. Go to HOLD with `instrOut`=0, `pcOut`=`fetchPC`, `excAdEL`=1. `fetchPC` is unchanged; the misaligned PC is held until a redirect replaces it.
- WAIT: on `imemRvalid`, latch `instrOut`<=`imemRdata`, `pcOut`<=`curPC`, `excAdEL`<=0, and go to HOLD.
- HOLD: `instrValid`=1.
  - On `idReady`, go to IDLE. The fetch issue is in IDLE.
  - Outputs remain stable while `idReady`=0.
- Delay slot rule: the first instruction delivered after the one in decode at redirect time is its PC+4 (the slot). After the slot, fetching continues at the target.
  - `redirect` in WAIT or HOLD: the slot is already in flight or buffered. `fetchPC` <= `redirectPC`.
  - `redirect` in IDLE with the request accepted in the same cycle: that request is the slot. `fetchPC` <= `redirectPC`.
  - `redirect` in IDLE without acceptance: the slot has not been issued. Set `pendValid`=1 and `pendTgt`=`redirectPC`. The target is consumed on the next acceptance.
  - A second `redirect` while `pendValid`=1 overwrites `pendTgt`; the later one wins. This case is architecturally illegal (branch in a delay slot) and is not flagged.
- `imemRvalid` outside WAIT is ignored.
- `fetchPC`+4 wraps modulo 2^32.

## Timing
- Reset (asynchronous assert, synchronous-safe release): state=IDLE, `fetchPC`=`RESET_PC`, `pendValid`=0, `curPC`=0, `instrOut`=0, `pcOut`=0, `instrValid`=0, `excAdEL`=0. `imemReq` goes to 1 in the first cycle after release.
- Reset asserted mid-WAIT abandons the request. A late `imemRvalid` after release is ignored, because state is IDLE and no matching request exists.
- `imemReq`, `imemAddr` and `instrValid` are decoded from registered state and `fetchPC`, with no combinational path from `imemReady` or `imemRvalid`.
- Minimum per-instruction cycle: IDLE→WAIT (1), WAIT→HOLD at 1-cycle memory latency (1), HOLD→IDLE with `idReady`=1 (1). Best case is 3 cycles per instruction.
- `imemReq` stays high with `imemAddr` stable until `imemReady`.

## Test plan
- Reset and sequential fetch: release `reset_n`; memory is always ready with 1-cycle latency; hold `idReady`=1 → `imemAddr` sequence is 0x3000, 0x3004, 0x3008; `pcOut` follows the same sequence; `excAdEL`=0.
- Decode stall: hold `idReady`=0 for 5 cycles while in HOLD at PC 0x3004 → `instrOut`/`pcOut` are stable; no new `imemReq`; exactly one delivery after release.
- Redirect in WAIT: deliver 0x3000 (branch); pulse `redirect` with `redirectPC`=0x3100 while 0x3004 is in flight → delivered PCs are 0x3000, 0x3004, 0x3100, 0x3104.
- Redirect in IDLE with `imemReady`=0 for 3 cycles: 0x3000 is in decode, `redirectPC`=0x3200 → 0x3004 is issued first, then 0x3200; `pendValid` clears.
- Misaligned target: `redirectPC`=0x3102 → after the slot, a delivery with `pcOut`=0x3102, `instrOut`=0, `excAdEL`=1, and no `imemReq` to 0x3102.
- Reset mid-WAIT: assert `reset_n`=0 while in WAIT; assert `imemRvalid` one cycle after release → output is not latched; first request is 0x3000.
